ucomb_sweep: RTL and testbench

//  Self-test sequencer for the universal-gate block and its reference model.

---
 rtl/ucomb_pkg.sv | 14 +
 rtl/ucomb_sweep_ctr.sv | 41 ++++
 rtl/ucomb_sweep.sv | 121 ++++++++++++
 tb/tb_ucomb_sweep.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ucomb_pkg.sv
// Shared types and widths for the universal-gate self-test sequencer.
package ucomb_pkg;
  localparam int FUNC_W = 16;
  localparam int SEL_W  = 2;
  localparam int PIN_W  = 4;
  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } ucomb_state_e;
endpackage

// File: rtl/ucomb_sweep_ctr.sv
// Nested sweep counter: vec is the inner digit, func the outer one.
// func_last is captured on load so the host may change it mid-sweep.
module ucomb_sweep_ctr
  import ucomb_pkg::*;
#(
  parameter int VEC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [FUNC_W-1:0] func_first,
  input  logic [FUNC_W-1:0] func_last,
  output logic [VEC_W-1:0]  vec,
  output logic [FUNC_W-1:0] func,
  output logic              last
);
  logic [FUNC_W-1:0] func_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec         <= '0;
      func        <= '0;
      func_last_q <= '0;
    end else if (load) begin
      vec         <= '0;
      func        <= func_first;
      func_last_q <= func_last;
    end else if (step) begin
      // The caller never steps on the final point, so func cannot wrap past 16'hFFFF.
      if (&vec) begin
        vec  <= '0;
        func <= func + FUNC_W'(1);
      end else begin
        vec <= vec + VEC_W'(1);
      end
    end
  end

  assign last = (&vec) && (func == func_last_q);
endmodule

// File: rtl/ucomb_sweep.sv
// Self-test sequencer: sweeps func/vec over the gate datapath and compares
// the datapath output against the reference model after each settle period.
module ucomb_sweep
  import ucomb_pkg::*;
#(
  parameter int VEC_W  = 4,
  parameter int CMP_W  = 6,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  sel_in,
  input  logic [PIN_W-1:0]  pin_in,
  input  logic [FUNC_W-1:0] func_first,
  input  logic [FUNC_W-1:0] func_last,
  input  logic [CMP_W-1:0]  cmp_mask,
  input  logic [CMP_W-1:0]  dut_out,
  input  logic [CMP_W-1:0]  ref_out,
  output logic [SEL_W-1:0]  cfg_sel,
  output logic [PIN_W-1:0]  cfg_pin,
  output logic [FUNC_W-1:0] cfg_func,
  output logic [VEC_W-1:0]  vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [FUNC_W-1:0] fail_func,
  output logic [VEC_W-1:0]  fail_vec
);
  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SETTLE - 1);

  ucomb_state_e      state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              start_ok, empty_range, mismatch, last, ctr_step, check_go;
  logic [15:0]       err_next;

  // Host protocol: start is a request taken only in IDLE (abort has priority);
  // done is a one-cycle completion pulse and results stay valid until the next accepted start.
  assign start_ok    = (state == IDLE) && start && !abort;
  assign empty_range = func_first > func_last;
  assign check_go    = (state == CHECK) && !abort;
  assign ctr_step    = check_go && !last;
  assign mismatch    = |((dut_out ^ ref_out) & cmp_mask);
  assign err_next    = (mismatch && (err_count != ERR_MAX)) ? err_count + 16'd1 : err_count;

  ucomb_sweep_ctr #(.VEC_W(VEC_W)) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_ok),
    .step       (ctr_step),
    .func_first (func_first),
    .func_last  (func_last),
    .vec        (vec),
    .func       (cfg_func),
    .last       (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = empty_range ? DONE : WAIT;
      WAIT:  if (abort) state_nxt = IDLE;
             else if (wait_cnt == '0) state_nxt = CHECK;
      CHECK: if (abort) state_nxt = IDLE;
             else state_nxt = last ? DONE : WAIT;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == WAIT) || (state == CHECK);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (start_ok || ctr_step) begin
      wait_cnt <= WAIT_INIT;
    end else if ((state == WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - WAIT_W'(1);
    end
  end

  // An abort landing on a CHECK cycle discards that sample entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_sel   <= '0;
      cfg_pin   <= '0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_func <= '0;
      fail_vec  <= '0;
    end else if (start_ok) begin
      cfg_sel   <= sel_in;
      cfg_pin   <= pin_in;
      pass      <= empty_range;
      err_count <= '0;
      fail_func <= '0;
      fail_vec  <= '0;
    end else if (check_go) begin
      err_count <= err_next;
      if (mismatch && (err_count == '0)) begin
        fail_func <= cfg_func;
        fail_vec  <= vec;
      end
      if (last) pass <= (err_next == '0);
    end else if (abort && (state != IDLE)) begin
      pass <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ucomb_sweep.sv
// Bench for ucomb_sweep: table-driven sweeps scored through an expected-result queue,
// plus hand sequences for reset, idle, abort and asynchronous reset mid-sweep.
module tb_ucomb_sweep;
  localparam int VEC_W = 4;
  localparam int CMP_W = 6;
  localparam int RES_W = 37;

  logic              clk, rst_n, start, abort;
  logic [1:0]        sel_in;
  logic [3:0]        pin_in;
  logic [15:0]       func_first, func_last;
  logic [CMP_W-1:0]  cmp_mask, dut_out, ref_out;
  logic [1:0]        cfg_sel;
  logic [3:0]        cfg_pin;
  logic [15:0]       cfg_func;
  logic [VEC_W-1:0]  vec;
  logic              busy, done, pass;
  logic [15:0]       err_count, fail_func;
  logic [VEC_W-1:0]  fail_vec;
  logic [1:0]        mode;
  logic [CMP_W-1:0]  base, fault;

  int tests = 0;
  int fails = 0;
  logic [RES_W-1:0] exp_q[$];

  typedef struct {
    logic [15:0] ff_in;
    logic [15:0] fl_in;
    logic [1:0]  sel;
    logic [3:0]  pin;
    logic [1:0]  mode;
    logic [5:0]  mask;
    logic [15:0] exp_err;
    logic [15:0] exp_ffunc;
    logic [3:0]  exp_fvec;
    logic        exp_pass;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[7];

  ucomb_sweep #(.VEC_W(VEC_W), .CMP_W(CMP_W), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sel_in(sel_in), .pin_in(pin_in), .func_first(func_first), .func_last(func_last),
    .cmp_mask(cmp_mask), .dut_out(dut_out), .ref_out(ref_out),
    .cfg_sel(cfg_sel), .cfg_pin(cfg_pin), .cfg_func(cfg_func), .vec(vec),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_func(fail_func), .fail_vec(fail_vec)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: the reference is a fixed function of the config, and the
  // "datapath" differs from it by a mode-selected fault pattern.
  always_comb begin
    base  = {2'b00, vec} ^ cfg_func[5:0];
    fault = '0;
    case (mode)
      2'd1: fault = (vec == 4'd5) ? 6'h01 : 6'h00;
      2'd2: fault = 6'h3F;
      2'd3: fault = vec[0] ? 6'h20 : 6'h00;
      default: fault = '0;
    endcase
    ref_out = base;
    dut_out = base ^ fault;
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] all_outs();
    return 80'({cfg_sel, cfg_pin, cfg_func, vec, busy, done, pass,
                err_count, fail_func, fail_vec});
  endfunction

  function automatic logic [RES_W-1:0] results();
    return {err_count, fail_func, fail_vec, pass};
  endfunction

  // Driver: one full sweep from a table entry, with trace and result checks.
  task automatic run_entry(input int idx, input vec_t t);
    int c;
    int bad;
    int bad_c;
    bit seen;
    logic [3:0]       ev;
    logic [15:0]      ef;
    logic [RES_W-1:0] exp_r;
    @(posedge clk); #1;
    sel_in = t.sel; pin_in = t.pin; func_first = t.ff_in; func_last = t.fl_in;
    mode = t.mode; cmp_mask = t.mask; start = 1'b1;
    exp_q.push_back({t.exp_err, t.exp_ffunc, t.exp_fvec, t.exp_pass});
    @(posedge clk); #1;
    start = 1'b0;
    sel_in = ~t.sel; pin_in = ~t.pin; func_first = 16'h0000; func_last = 16'h0000;
    c = 1; bad = 0; bad_c = 0; seen = 1'b0;
    while (!seen && c <= t.exp_cyc + 8) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        ev = 4'(((c - 1) / 2) % 16);
        ef = t.ff_in + 16'((c - 1) / 32);
        if (!busy || vec !== ev || cfg_func !== ef || cfg_sel !== t.sel || cfg_pin !== t.pin) begin
          if (bad == 0) bad_c = c;
          bad++;
        end
        start = (c == 5);
        @(posedge clk);
        c++;
      end
    end
    start = 1'b0;
    check($sformatf("t%0d done_cycle", idx), 80'(c), 80'(t.exp_cyc));
    check($sformatf("t%0d trace_bad_cycles(first %0d)", idx, bad_c), 80'(bad), 80'(0));
    if (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      check($sformatf("t%0d results", idx), 80'(results()), 80'(exp_r));
      if (t.ff_in > t.fl_in)
        check($sformatf("t%0d end_cfg", idx), 80'({cfg_func, vec}), 80'({t.ff_in, 4'h0}));
      else
        check($sformatf("t%0d end_cfg", idx), 80'({cfg_func, vec}), 80'({t.fl_in, 4'hF}));
      @(negedge clk);
      check($sformatf("t%0d persist", idx), 80'({busy, done, results()}), 80'({2'b00, exp_r}));
    end
  endtask

  initial begin
    logic [79:0] snap;
    int done_seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel_in = '0; pin_in = '0;
    func_first = '0; func_last = '0; cmp_mask = '0; mode = '0;

    tbl[0] = '{16'h6996, 16'h6996, 2'd1, 4'h5, 2'd0, 6'h3F, 16'd0,  16'h0000, 4'd0, 1'b1, 33};
    tbl[1] = '{16'h6996, 16'h6996, 2'd2, 4'hA, 2'd1, 6'h3F, 16'd1,  16'h6996, 4'd5, 1'b0, 33};
    tbl[2] = '{16'hFFFE, 16'hFFFF, 2'd3, 4'h3, 2'd2, 6'h3F, 16'd32, 16'hFFFE, 4'd0, 1'b0, 65};
    tbl[3] = '{16'h0005, 16'h0004, 2'd0, 4'h9, 2'd2, 6'h3F, 16'd0,  16'h0000, 4'd0, 1'b1, 1};
    tbl[4] = '{16'hFFFE, 16'hFFFF, 2'd1, 4'hC, 2'd2, 6'h00, 16'd0,  16'h0000, 4'd0, 1'b1, 65};
    tbl[5] = '{16'h0010, 16'h0012, 2'd2, 4'h6, 2'd3, 6'h20, 16'd24, 16'h0010, 4'd1, 1'b0, 97};
    tbl[6] = '{16'h0010, 16'h0012, 2'd3, 4'hF, 2'd3, 6'h1F, 16'd0,  16'h0000, 4'd0, 1'b1, 97};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", all_outs(), 80'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle_hold_%0d", i), all_outs(), 80'(0));
    end

    for (int i = 0; i < 7; i++) run_entry(i, tbl[i]);

    // Abort during the CHECK of vec 4: four earlier mismatches are kept.
    @(posedge clk); #1;
    sel_in = 2'd1; pin_in = 4'h2; func_first = 16'hFFFE; func_last = 16'hFFFF;
    mode = 2'd2; cmp_mask = 6'h3F; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_idle", 80'({busy, done}), 80'(0));
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort_no_done", 80'(done_seen), 80'(0));
    check("abort_results", 80'(results()), 80'({16'd4, 16'hFFFE, 4'd0, 1'b0}));

    // start and abort together in IDLE: nothing is accepted.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort", 80'({busy, done, err_count}), 80'({2'b00, 16'd4}));

    // Asynchronous reset in the middle of a sweep.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 snap = all_outs();
    check("async_reset_now", snap, 80'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("after_reset", all_outs(), 80'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
